vram_arb: RTL

Single-clock arbiter that shares one single-port, synchronous-read video RAM between two requesters: the CPU data port, which issues single-word reads and writes, and the display line fetcher, which issues sequential read bursts that fill a line buffer. Display bursts have priority. A starvation guard forces one CPU slot after a bounded wait. The block sits in the system clock domain, between the CPU bus decoder, the text/bitmap line fetch logic, and the VRAM instance.

---
 rtl/vram_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/vram_arb.sv
// vram_arb: shares one synchronous-read VRAM between CPU single-word accesses and display line bursts
module vram_arb #(
  parameter int ADDRW    = 14,
  parameter int DATAW    = 32,
  parameter int LENW     = 8,
  parameter int CPU_SLOT = 8
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [DATAW/8-1:0] cpu_wmask,
  input  logic [ADDRW-1:0]   cpu_addr,
  input  logic [DATAW-1:0]   cpu_wdata,
  output logic               cpu_ack,
  output logic [DATAW-1:0]   cpu_rdata,
  input  logic               ln_start,
  input  logic [ADDRW-1:0]   ln_addr,
  input  logic [LENW-1:0]    ln_len,
  output logic               ln_busy,
  output logic               ln_valid,
  output logic [DATAW-1:0]   ln_data,
  output logic               ln_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DATAW/8-1:0] mem_wmask,
  output logic [ADDRW-1:0]   mem_addr,
  output logic [DATAW-1:0]   mem_din,
  input  logic [DATAW-1:0]   mem_dout
);
  localparam int WW = $clog2(CPU_SLOT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;
  state_t           r_state, w_state_nx;
  logic [ADDRW-1:0] r_addr, w_bst_addr;
  logic [LENW-1:0]  r_rem, w_bst_rem;
  logic [WW-1:0]    r_wait;
  logic             r_inflight, r_mem_cpu, r_mem_bst, r_mem_last;
  logic             w_start_ok, w_bst_avail, w_cpu_elig, w_cpu_gnt, w_bst_gnt, w_last;
  // grant decision: a just-accepted burst issues in the same cycle, the guard overrides it
  always_comb begin
    w_start_ok  = ln_start && r_state == IDLE;
    w_bst_avail = r_state == BURST || (w_start_ok && ln_len != '0);
    w_bst_addr  = r_state == BURST ? r_addr : ln_addr;
    w_bst_rem   = r_state == BURST ? r_rem : ln_len;
    w_cpu_elig  = cpu_req && !r_inflight;
    w_cpu_gnt   = w_cpu_elig && (r_wait == WW'(CPU_SLOT) || !w_bst_avail);
    w_bst_gnt   = w_bst_avail && !w_cpu_gnt;
    w_last      = w_bst_gnt && w_bst_rem == LENW'(1);
    w_state_nx  = w_bst_gnt ? (w_last ? DRAIN : BURST) :
                  w_bst_avail ? BURST :
                  (r_state == DRAIN && ln_done) ? IDLE : r_state;
  end
  // state, burst counters, wait guard and registered VRAM/response outputs
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_wait     <= '0;
      r_inflight <= 1'b0;
      r_mem_cpu  <= 1'b0;
      r_mem_bst  <= 1'b0;
      r_mem_last <= 1'b0;
      cpu_ack    <= 1'b0;
      ln_valid   <= 1'b0;
      ln_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wmask  <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      r_state    <= w_state_nx;
      if (w_bst_avail) begin
        r_addr <= w_bst_gnt ? w_bst_addr + ADDRW'(1) : w_bst_addr;
        r_rem  <= w_bst_gnt ? w_bst_rem - LENW'(1) : w_bst_rem;
      end
      r_wait     <= w_cpu_gnt ? '0 : (w_cpu_elig && r_wait != WW'(CPU_SLOT)) ? r_wait + WW'(1) : r_wait;
      r_inflight <= w_cpu_gnt ? 1'b1 : cpu_ack ? 1'b0 : r_inflight;
      r_mem_cpu  <= w_cpu_gnt;
      r_mem_bst  <= w_bst_gnt;
      r_mem_last <= w_last;
      cpu_ack    <= r_mem_cpu;
      ln_valid   <= r_mem_bst;
      ln_done    <= r_mem_last || (w_start_ok && ln_len == '0);
      mem_en     <= w_cpu_gnt || w_bst_gnt;
      mem_we     <= w_cpu_gnt && cpu_we;
      mem_wmask  <= (w_cpu_gnt && cpu_we) ? cpu_wmask : '0;
      mem_addr   <= w_cpu_gnt ? cpu_addr : w_bst_gnt ? w_bst_addr : '0;
      mem_din    <= (w_cpu_gnt && cpu_we) ? cpu_wdata : '0;
    end
  end
  assign ln_busy   = r_state != IDLE;
  assign cpu_rdata = cpu_ack ? mem_dout : '0;
  assign ln_data   = ln_valid ? mem_dout : '0;
endmodule
